// File: rtl/processor_pio_pkg.sv
// Shared register-map constants and edge-select encodings for the processor PIO blocks.
package processor_pio_pkg;

  localparam logic [1:0] ADDR_DATA     = 2'd0;
  localparam logic [1:0] ADDR_EDGE_SEL = 2'd1;
  localparam logic [1:0] ADDR_IRQ_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE_CAP = 2'd3;

  typedef enum logic [1:0] {
    EDGE_NONE = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_ANY  = 2'b11
  } edge_sel_e;

  localparam edge_sel_e EDGE_SEL_RST = EDGE_RISE;

  // Bit 0 of the selector enables rising edges, bit 1 enables falling edges.
  function automatic logic edge_hit(input logic [1:0] sel, input logic rise, input logic fall);
    return (sel[0] & rise) | (sel[1] & fall);
  endfunction

endpackage

// File: rtl/processor_pin_entrada_if.sv
// Avalon-MM register-window bus between the interconnect (master) and the input PIO (slave).
interface processor_pin_entrada_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/processor_pin_entrada_debounce.sv
// One input bit: flip-flop synchronizer followed by an optional consecutive-cycle debouncer.
module processor_pin_entrada_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pin_i,
  output logic level_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      assign level_o = s;
    end else begin : g_debounce
      localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

      logic [CW-1:0] cnt_q, cnt_d;
      logic          stable_q, stable_d;

      // Any agreement between s and the accepted level restarts the run.
      always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        if (s == stable_q) begin
          cnt_d = '0;
        end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
          stable_d = s;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          cnt_q    <= '0;
          stable_q <= 1'b0;
        end else begin
          cnt_q    <= cnt_d;
          stable_q <= stable_d;
        end
      end

      assign level_o = stable_q;
    end
  endgenerate

endmodule

// File: rtl/processor_pin_entrada.sv
// Avalon-MM general-purpose input port: synchronized/debounced inputs, sticky edge capture, maskable irq.
module processor_pin_entrada
  import processor_pio_pkg::*;
#(
  parameter int DATA_WIDTH      = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  processor_pin_entrada_if.slave bus,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic                  irq
);

  logic [DATA_WIDTH-1:0] d;
  logic [DATA_WIDTH-1:0] d_prev_q;
  logic [DATA_WIDTH-1:0] qual;
  logic [DATA_WIDTH-1:0] irq_mask_q, irq_mask_d;
  logic [DATA_WIDTH-1:0] edge_cap_q, edge_cap_d;
  logic [DATA_WIDTH-1:0] w1c;
  edge_sel_e             edge_sel_q, edge_sel_d;
  logic                  wr_en;
  logic [31:0]           rdata;
  logic                  unused_wdata;

  assign wr_en        = bus.chipselect & ~bus.write_n;
  assign unused_wdata = ^bus.writedata;

  genvar gi;
  generate
    for (gi = 0; gi < DATA_WIDTH; gi++) begin : g_bit
      processor_pin_entrada_debounce #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
        .clk    (clk),
        .reset_n(reset_n),
        .pin_i  (in_port[gi]),
        .level_o(d[gi])
      );

      assign qual[gi] = edge_hit(edge_sel_q, d[gi] & ~d_prev_q[gi], ~d[gi] & d_prev_q[gi]);
    end
  endgenerate

  // A capture in the same cycle as a W1C of that bit wins because it is OR-ed in last.
  always_comb begin
    edge_sel_d = edge_sel_q;
    irq_mask_d = irq_mask_q;
    w1c        = '0;
    if (wr_en) begin
      case (bus.address)
        ADDR_EDGE_SEL: edge_sel_d = edge_sel_e'(bus.writedata[1:0]);
        ADDR_IRQ_MASK: irq_mask_d = bus.writedata[DATA_WIDTH-1:0];
        ADDR_EDGE_CAP: w1c        = bus.writedata[DATA_WIDTH-1:0];
        default:       ;
      endcase
    end
    edge_cap_d = (edge_cap_q & ~w1c) | qual;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      d_prev_q   <= '0;
      edge_sel_q <= EDGE_SEL_RST;
      irq_mask_q <= '0;
      edge_cap_q <= '0;
    end else begin
      d_prev_q   <= d;
      edge_sel_q <= edge_sel_d;
      irq_mask_q <= irq_mask_d;
      edge_cap_q <= edge_cap_d;
    end
  end

  always_comb begin
    rdata = '0;
    case (bus.address)
      ADDR_DATA:     rdata[DATA_WIDTH-1:0] = d;
      ADDR_EDGE_SEL: rdata[1:0]            = edge_sel_q;
      ADDR_IRQ_MASK: rdata[DATA_WIDTH-1:0] = irq_mask_q;
      ADDR_EDGE_CAP: rdata[DATA_WIDTH-1:0] = edge_cap_q;
      default:       ;
    endcase
  end

  assign bus.readdata = rdata;
  assign irq          = |(edge_cap_q & irq_mask_q);

endmodule

// File: tb/tb_processor_pin_entrada.sv
// Scoreboarded bench: two instances (no debounce / 4-cycle debounce) against a behavioural model.
module tb_processor_pin_entrada;
  localparam int DW  = 4;
  localparam int NDB = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic [DW-1:0] in0 = '0;
  logic [DW-1:0] in1 = '0;
  logic          irq0, irq1;

  processor_pin_entrada_if bus0 ();
  processor_pin_entrada_if bus1 ();

  processor_pin_entrada #(.DATA_WIDTH(DW), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .bus(bus0), .in_port(in0), .irq(irq0));
  processor_pin_entrada #(.DATA_WIDTH(DW), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(NDB)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(bus1), .in_port(in1), .irq(irq1));

  always #5 clk = ~clk;

  typedef struct {
    int          dut;
    logic [31:0] rd;
    logic        irq;
    string       name;
  } exp_t;

  exp_t expq[$];
  int   vectors = 0;
  int   miscompares = 0;
  logic rd_req = 1'b0;

  // Behavioural model: input history arrays; d flips once the last N samples of s all disagree with it.
  logic [DW-1:0] m_d     [2];
  logic [DW-1:0] m_dprev [2];
  logic [DW-1:0] m_mask  [2];
  logic [DW-1:0] m_cap   [2];
  logic [1:0]    m_sel   [2];
  logic [DW-1:0] in_hist [2][16];
  logic [DW-1:0] s_hist  [2][16];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_d[k] = '0; m_dprev[k] = '0; m_mask[k] = '0; m_cap[k] = '0; m_sel[k] = 2'b01;
      for (int i = 0; i < 16; i++) begin
        in_hist[k][i] = '0;
        s_hist[k][i]  = '0;
      end
    end
  endtask

  task automatic model_step(input int k, input logic [DW-1:0] in_v, input logic we,
                            input logic [1:0] addr, input logic [31:0] wd);
    logic [DW-1:0] d_pre, dp_pre, s_pre, d_new, rise, fall, qual, clr;
    logic all_diff;
    d_pre  = m_d[k];
    dp_pre = m_dprev[k];
    s_pre  = in_hist[k][1];
    for (int i = 15; i > 0; i--) in_hist[k][i] = in_hist[k][i-1];
    in_hist[k][0] = in_v;
    if (k == 0) begin
      d_new = in_hist[k][1];
    end else begin
      for (int i = 15; i > 0; i--) s_hist[k][i] = s_hist[k][i-1];
      s_hist[k][0] = s_pre;
      d_new = d_pre;
      for (int b = 0; b < DW; b++) begin
        all_diff = 1'b1;
        for (int i = 0; i < NDB; i++) if (s_hist[k][i][b] == d_pre[b]) all_diff = 1'b0;
        if (all_diff) d_new[b] = ~d_pre[b];
      end
    end
    rise = d_pre & ~dp_pre;
    fall = ~d_pre & dp_pre;
    qual = (m_sel[k][0] ? rise : '0) | (m_sel[k][1] ? fall : '0);
    clr  = (we && addr == 2'd3) ? wd[DW-1:0] : '0;
    m_cap[k] = (m_cap[k] & ~clr) | qual;
    if (we && addr == 2'd1) m_sel[k]  = wd[1:0];
    if (we && addr == 2'd2) m_mask[k] = wd[DW-1:0];
    m_dprev[k] = d_pre;
    m_d[k]     = d_new;
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      model_reset();
    end else begin
      model_step(0, in0, bus0.chipselect && !bus0.write_n, bus0.address, bus0.writedata);
      model_step(1, in1, bus1.chipselect && !bus1.write_n, bus1.address, bus1.writedata);
    end
  end

  function automatic logic [31:0] model_rd(input int k, input logic [1:0] a);
    logic [31:0] r;
    r = '0;
    case (a)
      2'd0: r[DW-1:0] = m_d[k];
      2'd1: r[1:0]    = m_sel[k];
      2'd2: r[DW-1:0] = m_mask[k];
      default: r[DW-1:0] = m_cap[k];
    endcase
    return r;
  endfunction

  function automatic logic model_irq(input int k);
    return |(m_cap[k] & m_mask[k]);
  endfunction

  // Driver helpers: all changes land 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
    bus0.chipselect = 1'b0; bus0.write_n = 1'b1;
    bus1.chipselect = 1'b0; bus1.write_n = 1'b1;
    rd_req = 1'b0;
  endtask

  task automatic wr(input int k, input logic [1:0] a, input logic [31:0] d);
    if (k == 0) begin
      bus0.chipselect = 1'b1; bus0.write_n = 1'b0; bus0.address = a; bus0.writedata = d;
    end else begin
      bus1.chipselect = 1'b1; bus1.write_n = 1'b0; bus1.address = a; bus1.writedata = d;
    end
  endtask

  task automatic push_exp(input int k, input logic [1:0] a, input logic [31:0] e,
                          input logic ei, input string name);
    exp_t x;
    if (k == 0) bus0.address = a; else bus1.address = a;
    x.dut = k; x.rd = e; x.irq = ei; x.name = name;
    expq.push_back(x);
    rd_req = 1'b1;
  endtask

  task automatic rd_model(input int k, input logic [1:0] a, input string name);
    push_exp(k, a, model_rd(k, a), model_irq(k), name);
  endtask

  task automatic rd_const(input int k, input logic [1:0] a, input logic [31:0] e,
                          input logic ei, input string name);
    push_exp(k, a, e, ei, name);
  endtask

  // Monitor: consume one expectation per presented read, independent of the driver.
  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] act;
    logic        ai;
    if (rd_req) begin
      vectors++;
      if (expq.size() == 0) begin
        miscompares++;
        $display("FAIL scoreboard_underflow: read presented with no expectation queued");
      end else begin
        e   = expq.pop_front();
        act = (e.dut == 0) ? bus0.readdata : bus1.readdata;
        ai  = (e.dut == 0) ? irq0 : irq1;
        if (act !== e.rd || ai !== e.irq) begin
          miscompares++;
          $display("FAIL %s dut%0d: got readdata=%h irq=%b, want readdata=%h irq=%b",
                   e.name, e.dut, act, ai, e.rd, e.irq);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int hold0, hold1, wk, rk;
    logic [1:0]  wa, ra;
    logic [31:0] wd;
    bus0.chipselect = 1'b0; bus0.write_n = 1'b1; bus0.address = '0; bus0.writedata = '0;
    bus1.chipselect = 1'b0; bus1.write_n = 1'b1; bus1.address = '0; bus1.writedata = '0;
    #1 reset_n = 1'b0;
    repeat (3) step();
    reset_n = 1'b1;

    rd_const(0, 0, 0, 0, "rst_data");     step();
    rd_const(0, 1, 1, 0, "rst_edge_sel"); step();
    rd_const(0, 2, 0, 0, "rst_mask");     step();
    rd_const(0, 3, 0, 0, "rst_cap");      step();

    // Rising capture through the two-flop synchronizer
    wr(0, 2, 32'h1); step();
    in0 = 4'h1; rd_const(0, 2, 1, 0, "mask_set"); step();
    rd_const(0, 0, 0, 0, "data_after_e1"); step();
    rd_const(0, 0, 1, 0, "data_after_e2"); step();
    rd_const(0, 3, 1, 1, "cap_after_e3");  step();
    wr(0, 3, 32'h1); rd_const(0, 3, 1, 1, "cap_before_w1c"); step();
    rd_const(0, 3, 0, 0, "w1c_clear"); step();

    // Capture and W1C on the same edge
    in0 = 4'h0; repeat (4) step();
    in0 = 4'h1; step(); step();
    wr(0, 3, 32'h1); step();
    rd_const(0, 3, 1, 1, "set_wins_clear"); step();
    wr(0, 3, 32'h1); step();
    rd_const(0, 3, 0, 0, "w1c_again"); step();

    // Falling-only selection
    wr(0, 1, 32'h2); step();
    in0 = 4'h3; repeat (4) step();
    rd_const(0, 3, 0, 0, "fall_sel_ignores_rise"); step();
    in0 = 4'h1; repeat (4) step();
    rd_const(0, 3, 2, 0, "fall_cap"); step();

    // Any-edge selection with irq masked off
    wr(0, 3, 32'hF); step();
    wr(0, 2, 32'h0); step();
    wr(0, 1, 32'h3); step();
    in0 = 4'h9; repeat (4) step();
    in0 = 4'h1; repeat (4) step();
    rd_const(0, 3, 8, 0, "any_cap_bit3"); step();

    // DATA is read-only; upper write bits ignored
    wr(0, 0, 32'hFFFF_FFFF); step();
    rd_const(0, 0, 1, 0, "data_ro");            step();
    rd_const(0, 1, 3, 0, "sel_after_data_wr");  step();
    rd_const(0, 2, 0, 0, "mask_after_data_wr"); step();
    rd_const(0, 3, 8, 0, "cap_after_data_wr");  step();
    wr(0, 2, 32'hFFFF_FFFF); step();
    rd_const(0, 2, 32'hF, 1, "mask_upper_ignored"); step();

    // Asynchronous reset with every capture bit set
    in0 = ~in0; repeat (4) step();
    rd_const(0, 3, 32'hF, 1, "cap_all"); step();
    reset_n = 1'b0;
    rd_const(0, 0, 0, 0, "rst_mid_data"); step();
    rd_const(0, 1, 1, 0, "rst_mid_sel");  step();
    rd_const(0, 2, 0, 0, "rst_mid_mask"); step();
    rd_const(0, 3, 0, 0, "rst_mid_cap");  step();
    in0 = 4'h0; reset_n = 1'b1; step(); step();

    // Debounce N=4: a 3-cycle glitch is rejected
    wr(1, 2, 32'h1); step();
    in1 = 4'h1; step(); step(); step();
    in1 = 4'h0;
    for (int i = 0; i < 10; i++) begin
      rd_const(1, (i % 2 == 0) ? 2'd0 : 2'd3, 0, 0, "glitch_rejected");
      step();
    end

    // 6-cycle pulse: accepted at edge 2+4, captured one edge later
    in1 = 4'h1;
    for (int i = 1; i <= 5; i++) begin
      step();
      rd_const(1, 0, 0, 0, "db_pending");
    end
    step();
    rd_const(1, 0, 1, 0, "db_data_e6");
    in1 = 4'h0;
    step();
    rd_const(1, 3, 1, 1, "db_cap_e7");
    step();

    // Randomized traffic against the model
    hold0 = 0; hold1 = 0;
    for (int c = 0; c < 800; c++) begin
      if (hold0 == 0) begin in0 = DW'($urandom); hold0 = $urandom_range(1, 6); end
      else hold0--;
      if (hold1 == 0) begin in1 = DW'($urandom); hold1 = $urandom_range(1, 10); end
      else hold1--;
      wk = -1; wa = '0;
      if ($urandom_range(0, 5) == 0) begin
        wk = $urandom_range(0, 1);
        wa = 2'($urandom);
        wd = $urandom;
        wr(wk, wa, wd);
      end
      rk = $urandom_range(0, 1);
      ra = (rk == wk) ? wa : 2'($urandom);
      rd_model(rk, ra, "random");
      step();
    end

    if (expq.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_leftover: %0d expectations unconsumed, want 0", expq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
